platform_field: RTL and testbench

//  Parametrised platform (stair) manager for the vertical-scroller game. Holds N_PLAT platforms,

---
 rtl/platform_field.sv | 218 +++++++++++++++++++++
 tb/tb_platform_field.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/platform_field.sv
// Platform (stair) manager for the vertical scroller: scrolls, bounces and respawns
// N_PLAT platforms and reports per-pixel hits plus spring geometry.

module platform_lane #(
  parameter int IDX      = 0,
  parameter int HALF_W   = 20,
  parameter int HALF_H   = 5,
  parameter int X_MIN    = 170,
  parameter int X_MAX    = 469,
  parameter int Y_MAX    = 479,
  parameter int Y0       = 30,
  parameter int SPACING  = 30,
  parameter int SPD_MAX  = 3,
  parameter int PARK     = 600,
  parameter int TOOL_OFS = 10,
  parameter int TOOL_SZ  = 7
) (
  input  logic       frame_clk,
  input  logic       Reset,
  input  logic [8:0] lfsr_i,
  input  logic [9:0] scroll_i,
  input  logic [9:0] draw_x_i,
  input  logic [9:0] draw_y_i,
  input  logic       move_en_i,
  input  logic       active_i,
  input  logic       spring_en_i,
  output logic [9:0] x_o,
  output logic [9:0] y_o,
  output logic       parked_o,
  output logic       respawn_o,
  output logic       hit_o,
  output logic [9:0] tool_x_o,
  output logic [9:0] tool_y_o,
  output logic [9:0] tool_s_o
);

  localparam int RANGE = X_MAX - X_MIN - 2*HALF_W + 1;
  localparam int SPD   = 1 + (IDX % SPD_MAX);

  localparam logic [9:0] X_RST  = 10'(X_MIN + HALF_W + (IDX*67) % RANGE);
  localparam logic [9:0] Y_RST  = 10'(Y0 + IDX*SPACING);
  localparam logic [9:0] X_LO   = 10'(X_MIN + HALF_W);
  localparam logic [9:0] X_HI   = 10'(X_MAX - HALF_W);
  localparam logic [9:0] PARK10 = 10'(PARK);
  localparam logic [9:0] SPD10  = 10'(SPD);
  localparam logic [8:0] MIX    = 9'(IDX * 32'h9E37);
  localparam logic [8:0] RNG9   = 9'(RANGE);

  localparam logic signed [10:0] SPD_S  = 11'(SPD);
  localparam logic signed [10:0] HW_S   = 11'(HALF_W);
  localparam logic signed [10:0] HH_S   = 11'(HALF_H);
  localparam logic signed [10:0] XMIN_S = 11'(X_MIN);
  localparam logic signed [10:0] XMAX_S = 11'(X_MAX);

  logic [9:0] x_q, x_d, y_q, y_d;
  logic       dir_q, dir_d;        // 1 = moving left
  logic       parked_q, parked_d;
  logic       respawn_q, respawn_d;

  logic [8:0] r_raw, r_fold;
  logic [9:0] rx;
  logic       wrap;
  logic signed [10:0] xs, ys, dx, dy, adx, ady;

  // Per-lane mix of the shared LFSR so same-frame respawns land apart.
  assign r_raw  = lfsr_i ^ MIX;
  assign r_fold = (r_raw >= RNG9) ? r_raw - RNG9 : r_raw;
  assign rx     = X_LO + {1'b0, r_fold};

  assign wrap = (y_q > 10'(Y_MAX));
  assign xs   = $signed({1'b0, x_q});
  assign ys   = $signed({1'b0, y_q});

  always_comb begin
    x_d       = x_q;
    y_d       = y_q;
    dir_d     = dir_q;
    parked_d  = parked_q;
    respawn_d = 1'b0;
    if ((wrap || parked_q) && active_i) begin
      x_d       = rx;
      y_d       = '0;
      parked_d  = 1'b0;
      respawn_d = 1'b1;
    end else if (wrap || parked_q) begin
      x_d      = PARK10;
      y_d      = PARK10;
      parked_d = 1'b1;
    end else begin
      y_d = y_q - scroll_i;
      if (move_en_i) begin
        // Edge clamps only apply in the direction of travel so a bounce can leave the wall.
        if (!dir_q && (xs + SPD_S + HW_S >= XMAX_S)) begin
          x_d   = X_HI;
          dir_d = 1'b1;
        end else if (dir_q && (xs - SPD_S - HW_S <= XMIN_S)) begin
          x_d   = X_LO;
          dir_d = 1'b0;
        end else begin
          x_d = dir_q ? x_q - SPD10 : x_q + SPD10;
        end
      end
    end
  end

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) begin
      x_q       <= X_RST;
      y_q       <= Y_RST;
      dir_q     <= 1'b0;
      parked_q  <= 1'b0;
      respawn_q <= 1'b0;
    end else begin
      x_q       <= x_d;
      y_q       <= y_d;
      dir_q     <= dir_d;
      parked_q  <= parked_d;
      respawn_q <= respawn_d;
    end
  end

  always_comb begin
    dx    = $signed({1'b0, draw_x_i}) - xs;
    dy    = $signed({1'b0, draw_y_i}) - ys;
    adx   = dx[10] ? -dx : dx;
    ady   = dy[10] ? -dy : dy;
    hit_o = !parked_q && (adx <= HW_S) && (ady <= HH_S);
  end

  assign x_o       = x_q;
  assign y_o       = y_q;
  assign parked_o  = parked_q;
  assign respawn_o = respawn_q;
  assign tool_x_o  = x_q;
  assign tool_y_o  = y_q - 10'(TOOL_OFS);
  assign tool_s_o  = (spring_en_i && !parked_q) ? 10'(TOOL_SZ) : 10'd0;

endmodule

module platform_field #(
  parameter int          N_PLAT   = 14,
  parameter int          HALF_W   = 20,
  parameter int          HALF_H   = 5,
  parameter int          X_MIN    = 170,
  parameter int          X_MAX    = 469,
  parameter int          Y_MAX    = 479,
  parameter int          Y0       = 30,
  parameter int          SPACING  = 30,
  parameter int          SPD_MAX  = 3,
  parameter int          PARK     = 600,
  parameter int          TOOL_OFS = 10,
  parameter int          TOOL_SZ  = 7,
  parameter logic [15:0] SEED     = 16'hACE1
) (
  input  logic                   frame_clk,
  input  logic                   Reset,
  input  logic [9:0]             DrawX,
  input  logic [9:0]             DrawY,
  input  logic [9:0]             scroll,
  input  logic [N_PLAT-1:0]      move_en,
  input  logic [N_PLAT-1:0]      active,
  input  logic [N_PLAT-1:0]      spring_en,
  output logic [N_PLAT-1:0][9:0] plat_x,
  output logic [N_PLAT-1:0][9:0] plat_y,
  output logic [N_PLAT-1:0]      parked,
  output logic [N_PLAT-1:0]      respawn,
  output logic [N_PLAT-1:0]      hit,
  output logic                   any_hit,
  output logic [N_PLAT-1:0][9:0] tool_x,
  output logic [N_PLAT-1:0][9:0] tool_y,
  output logic [N_PLAT-1:0][9:0] tool_s
);

  localparam int RANGE = X_MAX - X_MIN - 2*HALF_W + 1;

  // The 9-bit random offset plus one fold only covers [0,RANGE) for this window.
  if (RANGE < 256 || RANGE > 511) begin : g_range_chk
    $error("platform_field: RANGE=%0d outside [256,511]", RANGE);
  end

  logic [15:0] lfsr_q, lfsr_d;

  assign lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};

  always_ff @(posedge frame_clk or posedge Reset) begin
    if (Reset) lfsr_q <= SEED;
    else       lfsr_q <= lfsr_d;
  end

  for (genvar i = 0; i < N_PLAT; i++) begin : g_lane
    platform_lane #(
      .IDX(i), .HALF_W(HALF_W), .HALF_H(HALF_H), .X_MIN(X_MIN), .X_MAX(X_MAX),
      .Y_MAX(Y_MAX), .Y0(Y0), .SPACING(SPACING), .SPD_MAX(SPD_MAX), .PARK(PARK),
      .TOOL_OFS(TOOL_OFS), .TOOL_SZ(TOOL_SZ)
    ) u_lane (
      .frame_clk  (frame_clk),
      .Reset      (Reset),
      .lfsr_i     (lfsr_q[8:0]),
      .scroll_i   (scroll),
      .draw_x_i   (DrawX),
      .draw_y_i   (DrawY),
      .move_en_i  (move_en[i]),
      .active_i   (active[i]),
      .spring_en_i(spring_en[i]),
      .x_o        (plat_x[i]),
      .y_o        (plat_y[i]),
      .parked_o   (parked[i]),
      .respawn_o  (respawn[i]),
      .hit_o      (hit[i]),
      .tool_x_o   (tool_x[i]),
      .tool_y_o   (tool_y[i]),
      .tool_s_o   (tool_s[i])
    );
  end

  assign any_hit = |hit;

endmodule

// File: tb/tb_platform_field.sv
// Directed bench for platform_field: reset image, bouncing, wrap/respawn, parking,
// hit window and asynchronous mid-run reset.

module tb_platform_field;

  localparam int N = 14;

  logic              frame_clk = 1'b0;
  logic              Reset = 1'b0;
  logic [9:0]        DrawX = '0, DrawY = '0, scroll = '0;
  logic [N-1:0]      move_en = '0, active = '0, spring_en = '0;
  logic [N-1:0][9:0] plat_x, plat_y, tool_x, tool_y, tool_s;
  logic [N-1:0]      parked, respawn, hit;
  logic              any_hit;

  int n_chk = 0;
  int n_fail = 0;

  logic [15:0] m_lfsr;

  platform_field dut (
    .frame_clk(frame_clk), .Reset(Reset), .DrawX(DrawX), .DrawY(DrawY),
    .scroll(scroll), .move_en(move_en), .active(active), .spring_en(spring_en),
    .plat_x(plat_x), .plat_y(plat_y), .parked(parked), .respawn(respawn),
    .hit(hit), .any_hit(any_hit), .tool_x(tool_x), .tool_y(tool_y), .tool_s(tool_s)
  );

  always #5 frame_clk = ~frame_clk;

  // Reference LFSR: right-shifting Fibonacci, taps 16,14,13,11.
  always @(posedge frame_clk or posedge Reset)
    if (Reset) m_lfsr <= 16'hACE1;
    else       m_lfsr <= {m_lfsr[0] ^ m_lfsr[2] ^ m_lfsr[3] ^ m_lfsr[5], m_lfsr[15:1]};

  task automatic step();
    @(posedge frame_clk);
    @(negedge frame_clk);
  endtask

  task automatic do_reset();
    @(negedge frame_clk);
    Reset = 1'b1;
    scroll = '0; move_en = '0; active = '1; spring_en = '0;
    @(negedge frame_clk);
    Reset = 1'b0;
  endtask

  function automatic logic [9:0] exp_rx(input logic [15:0] l, input int idx);
    logic [15:0] m;
    logic [8:0]  r;
    m = l ^ 16'(idx * 32'h9E37);
    r = m[8:0];
    if (r >= 9'd260) r = r - 9'd260;
    return 10'd190 + {1'b0, r};
  endfunction

  task automatic test_reset();
    @(negedge frame_clk);
    Reset = 1'b1; scroll = '0; move_en = '0; active = '1; spring_en = '0;
    spring_en[3] = 1'b1;
    #1;
    n_chk++; if (plat_y[3] !== 10'd120) begin n_fail++; $display("FAIL rst_y3 got %0d exp 120", plat_y[3]); end
    n_chk++; if (plat_x[3] !== 10'd391) begin n_fail++; $display("FAIL rst_x3 got %0d exp 391", plat_x[3]); end
    n_chk++; if (plat_x[13] !== 10'd281) begin n_fail++; $display("FAIL rst_x13 got %0d exp 281", plat_x[13]); end
    n_chk++; if (respawn !== '0 || parked !== '0) begin n_fail++; $display("FAIL rst_flags got %h/%h exp 0/0", respawn, parked); end
    n_chk++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL rst_lfsr got %h exp ace1", dut.lfsr_q); end
    n_chk++; if (tool_y[3] !== 10'd110) begin n_fail++; $display("FAIL rst_tool_y3 got %0d exp 110", tool_y[3]); end
    n_chk++; if (tool_s[3] !== 10'd7 || tool_s[1] !== 10'd0) begin n_fail++; $display("FAIL rst_tool_s got %0d/%0d exp 7/0", tool_s[3], tool_s[1]); end
    @(negedge frame_clk);
    Reset = 1'b0;
    step();
    n_chk++; if (plat_y[3] !== 10'd120) begin n_fail++; $display("FAIL f1_y3 got %0d exp 120", plat_y[3]); end
    n_chk++; if (plat_x[3] !== 10'd391) begin n_fail++; $display("FAIL f1_x3 got %0d exp 391", plat_x[3]); end
    n_chk++; if (respawn !== '0) begin n_fail++; $display("FAIL f1_respawn got %h exp 0", respawn); end
    n_chk++; if (dut.lfsr_q !== 16'h5670) begin n_fail++; $display("FAIL f1_lfsr got %h exp 5670", dut.lfsr_q); end
  endtask

  task automatic test_move();
    do_reset();
    move_en[0] = 1'b1;
    repeat (258) step();
    n_chk++; if (plat_x[0] !== 10'd448) begin n_fail++; $display("FAIL mv_x448 got %0d exp 448", plat_x[0]); end
    n_chk++; if (plat_y[0] !== 10'd30 || plat_x[1] !== 10'd257) begin n_fail++; $display("FAIL mv_frozen got y0=%0d x1=%0d exp 30/257", plat_y[0], plat_x[1]); end
    step();
    n_chk++; if (plat_x[0] !== 10'd449) begin n_fail++; $display("FAIL mv_clamp got %0d exp 449", plat_x[0]); end
    step();
    n_chk++; if (plat_x[0] !== 10'd448) begin n_fail++; $display("FAIL mv_back1 got %0d exp 448", plat_x[0]); end
    step();
    n_chk++; if (plat_x[0] !== 10'd447) begin n_fail++; $display("FAIL mv_back2 got %0d exp 447", plat_x[0]); end
  endtask

  task automatic test_wrap_respawn();
    logic [9:0] ex;
    int n;
    do_reset();
    scroll = 10'd726;
    step();
    n_chk++; if (plat_y[5] !== 10'd478) begin n_fail++; $display("FAIL wr_y478 got %0d exp 478", plat_y[5]); end
    scroll = 10'd5;
    step();
    n_chk++; if (plat_y[5] !== 10'd473) begin n_fail++; $display("FAIL wr_y473 got %0d exp 473", plat_y[5]); end
    n = 0;
    while (plat_y[5] <= 10'd479 && n < 200) begin step(); n++; end
    n_chk++; if (n != 95 || plat_y[5] !== 10'd1022) begin n_fail++; $display("FAIL wr_under got %0d after %0d exp 1022 after 95", plat_y[5], n); end
    ex = exp_rx(m_lfsr, 5);
    step();
    n_chk++; if (plat_y[5] !== 10'd0) begin n_fail++; $display("FAIL wr_y0 got %0d exp 0", plat_y[5]); end
    n_chk++; if (plat_x[5] !== ex || plat_x[5] < 10'd190 || plat_x[5] > 10'd449) begin n_fail++; $display("FAIL wr_rx got %0d exp %0d", plat_x[5], ex); end
    n_chk++; if (respawn[5] !== 1'b1 || parked[5] !== 1'b0) begin n_fail++; $display("FAIL wr_pulse got r=%b p=%b exp 1/0", respawn[5], parked[5]); end
    scroll = '0;
    step();
    n_chk++; if (respawn[5] !== 1'b0) begin n_fail++; $display("FAIL wr_pulse_clr got %b exp 0", respawn[5]); end
  endtask

  task automatic test_park();
    logic [9:0] ex;
    do_reset();
    active[2] = 1'b0; spring_en[2] = 1'b1;
    scroll = 10'd91;
    step();
    n_chk++; if (plat_y[2] !== 10'd1023 || parked[2] !== 1'b0) begin n_fail++; $display("FAIL pk_under got y=%0d p=%b exp 1023/0", plat_y[2], parked[2]); end
    scroll = '0;
    step();
    n_chk++; if (plat_x[2] !== 10'd600 || plat_y[2] !== 10'd600) begin n_fail++; $display("FAIL pk_xy got %0d,%0d exp 600,600", plat_x[2], plat_y[2]); end
    n_chk++; if (parked[2] !== 1'b1 || respawn[2] !== 1'b0) begin n_fail++; $display("FAIL pk_flag got p=%b r=%b exp 1/0", parked[2], respawn[2]); end
    DrawX = 10'd600; DrawY = 10'd600;
    #1;
    n_chk++; if (hit[2] !== 1'b0 || tool_s[2] !== 10'd0) begin n_fail++; $display("FAIL pk_masked got hit=%b s=%0d exp 0/0", hit[2], tool_s[2]); end
    step();
    n_chk++; if (parked[2] !== 1'b1) begin n_fail++; $display("FAIL pk_hold got %b exp 1", parked[2]); end
    active[2] = 1'b1;
    ex = exp_rx(m_lfsr, 2);
    step();
    n_chk++; if (plat_y[2] !== 10'd0 || parked[2] !== 1'b0 || respawn[2] !== 1'b1) begin n_fail++; $display("FAIL pk_respawn got y=%0d p=%b r=%b exp 0/0/1", plat_y[2], parked[2], respawn[2]); end
    n_chk++; if (plat_x[2] !== ex || tool_s[2] !== 10'd7) begin n_fail++; $display("FAIL pk_rx got x=%0d s=%0d exp %0d/7", plat_x[2], tool_s[2], ex); end
  endtask

  task automatic test_hit();
    do_reset();
    move_en[6] = 1'b1;
    repeat (266) step();
    n_chk++; if (plat_x[6] !== 10'd300) begin n_fail++; $display("FAIL ht_x got %0d exp 300", plat_x[6]); end
    move_en = '0; scroll = 10'd10;
    step();
    scroll = '0;
    n_chk++; if (plat_y[6] !== 10'd200) begin n_fail++; $display("FAIL ht_y got %0d exp 200", plat_y[6]); end
    DrawX = 10'd280; DrawY = 10'd195; #1;
    n_chk++; if (hit[6] !== 1'b1 || any_hit !== 1'b1) begin n_fail++; $display("FAIL ht_280_195 got %b/%b exp 1/1", hit[6], any_hit); end
    DrawX = 10'd279; DrawY = 10'd195; #1;
    n_chk++; if (hit[6] !== 1'b0 || any_hit !== 1'b0) begin n_fail++; $display("FAIL ht_279_195 got %b/%b exp 0/0", hit[6], any_hit); end
    DrawX = 10'd320; DrawY = 10'd205; #1;
    n_chk++; if (hit[6] !== 1'b1) begin n_fail++; $display("FAIL ht_320_205 got %b exp 1", hit[6]); end
    DrawX = 10'd300; DrawY = 10'd206; #1;
    n_chk++; if (hit[6] !== 1'b0) begin n_fail++; $display("FAIL ht_300_206 got %b exp 0", hit[6]); end
  endtask

  task automatic test_reset_mid();
    do_reset();
    scroll = 10'd7; move_en = '1;
    repeat (20) step();
    n_chk++; if (dut.lfsr_q === 16'hACE1) begin n_fail++; $display("FAIL mr_lfsr_run got %h exp not ace1", dut.lfsr_q); end
    #2 Reset = 1'b1;
    #1;
    n_chk++; if (plat_y[3] !== 10'd120 || plat_x[0] !== 10'd190) begin n_fail++; $display("FAIL mr_async got y3=%0d x0=%0d exp 120/190", plat_y[3], plat_x[0]); end
    n_chk++; if (dut.lfsr_q !== 16'hACE1) begin n_fail++; $display("FAIL mr_lfsr got %h exp ace1", dut.lfsr_q); end
    scroll = '0; move_en = '0;
    @(negedge frame_clk);
    Reset = 1'b0;
    step();
    n_chk++; if (plat_y[3] !== 10'd120 || plat_x[3] !== 10'd391) begin n_fail++; $display("FAIL mr_f1 got y3=%0d x3=%0d exp 120/391", plat_y[3], plat_x[3]); end
    n_chk++; if (respawn !== '0 || dut.lfsr_q !== 16'h5670) begin n_fail++; $display("FAIL mr_f1_state got r=%h l=%h exp 0/5670", respawn, dut.lfsr_q); end
  endtask

  initial begin
    test_reset();
    test_move();
    test_wrap_respawn();
    test_park();
    test_hit();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
